// File: rtl/pedestrian_crossing_ctrl.sv
// rtl/pedestrian_crossing_ctrl.sv - push-button pedestrian crossing signal controller
//
// Vehicle traffic holds green until a latched pedestrian request is seen after
// the minimum green time, then runs yellow, all-red, walk, all-red and back.
// Lamps are a pure Moore decode of the state register.

module pedestrian_crossing_ctrl #(
  parameter int MIN_GREEN = 20,
  parameter int YELLOW_T  = 5,
  parameter int CLEAR_T   = 3,
  parameter int PED_T     = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic buton,
  output logic car_red,
  output logic car_yellow,
  output logic car_green,
  output logic ped_red,
  output logic ped_green,
  output logic req_pending
);

  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    ALL_RED    = 3'd2,
    PED_WALK   = 3'd3,
    PED_CLEAR  = 3'd4
  } state_t;

  // Terminal timer values for the fixed-length phases.
  localparam logic [15:0] YELLOW_LAST = 16'(YELLOW_T - 1);
  localparam logic [15:0] CLEAR_LAST  = 16'(CLEAR_T - 1);
  localparam logic [15:0] WALK_LAST   = 16'(PED_T - 1);
  // Minimum green is tested as timer+1 >= MIN_GREEN so MIN_GREEN=1 needs no
  // compare against zero.
  localparam logic [16:0] GREEN_MIN   = 17'(MIN_GREEN);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] timer_q;
  logic        req_q;
  logic        req_d;
  logic        green_done;
  logic        enter_walk;

  assign green_done  = ({1'b0, timer_q} + 17'd1) >= GREEN_MIN;
  assign enter_walk  = (state_q == ALL_RED) && (state_d == PED_WALK);
  assign req_pending = req_q;

  // State register: reset always lands in CAR_GREEN with no intermediate phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CAR_GREEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase timer: restarts at 0 on every transition, saturates while parked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= 16'd0;
    end else if (state_d != state_q) begin
      timer_q <= 16'd0;
    end else if (timer_q != 16'hFFFF) begin
      timer_q <= timer_q + 16'd1;
    end
  end

  // Request latch register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  // Request latch next value: entering the walk phase serves the request and
  // takes priority over a press in that same cycle; presses during the walk
  // itself are already being served and are dropped.
  always_comb begin
    req_d = req_q;
    if (enter_walk) begin
      req_d = 1'b0;
    end else if (buton && (state_q != PED_WALK)) begin
      req_d = 1'b1;
    end
  end

  // Next-state logic: green waits for both the minimum time and a request,
  // every other phase is a fixed-length countdown.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAR_GREEN: begin
        if (green_done && req_q) begin
          state_d = CAR_YELLOW;
        end
      end
      CAR_YELLOW: begin
        if (timer_q == YELLOW_LAST) begin
          state_d = ALL_RED;
        end
      end
      ALL_RED: begin
        if (timer_q == CLEAR_LAST) begin
          state_d = PED_WALK;
        end
      end
      PED_WALK: begin
        if (timer_q == WALK_LAST) begin
          state_d = PED_CLEAR;
        end
      end
      PED_CLEAR: begin
        if (timer_q == CLEAR_LAST) begin
          state_d = CAR_GREEN;
        end
      end
      default: begin
        state_d = CAR_GREEN;
      end
    endcase
  end

  // Lamp decode: exactly one car lamp and one ped lamp per state, and the
  // ped green lamp only ever appears with car red.
  always_comb begin
    car_red    = 1'b0;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    ped_red    = 1'b1;
    ped_green  = 1'b0;
    case (state_q)
      CAR_GREEN:  car_green  = 1'b1;
      CAR_YELLOW: car_yellow = 1'b1;
      ALL_RED:    car_red    = 1'b1;
      PED_WALK: begin
        car_red   = 1'b1;
        ped_red   = 1'b0;
        ped_green = 1'b1;
      end
      PED_CLEAR:  car_red    = 1'b1;
      default:    car_red    = 1'b1;
    endcase
  end

endmodule

// File: doc/pedestrian_crossing_ctrl.md
PEDESTRIAN_CROSSING_CTRL -- requirements
Module: pedestrian_crossing_ctrl

Interface
REQ-001 Parameter MIN_GREEN, default 20: minimum CAR_GREEN duration in clk cycles; legal range 1..65535.
REQ-002 Parameter YELLOW_T, default 5: CAR_YELLOW duration in clk cycles; legal range 1..65535.
REQ-003 Parameter CLEAR_T, default 3: duration of each all-red state in clk cycles; legal range 1..65535.
REQ-004 Parameter PED_T, default 15: PED_WALK duration in clk cycles; legal range 1..65535.
REQ-005 clk  input  1  single system clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 buton  input  1  debounced pedestrian request, a one-cycle-high pulse synchronous to clk.
REQ-008 car_red, car_yellow, car_green  output  1 each  vehicle signal heads.
REQ-009 ped_red, ped_green  output  1 each  pedestrian signal heads.
REQ-010 req_pending  output  1  "request registered" indicator lamp, equal to the request latch.

Function
REQ-011 The FSM SHALL have states CAR_GREEN, CAR_YELLOW, ALL_RED, PED_WALK, PED_CLEAR.
REQ-012 A 16-bit phase timer SHALL load 0 on every state transition and otherwise increment by 1 per cycle, saturating at 65535.
REQ-013 CAR_GREEN -> CAR_YELLOW when timer >= MIN_GREEN-1 and req_pending=1 in the same cycle; otherwise remain.
REQ-014 CAR_YELLOW -> ALL_RED when timer == YELLOW_T-1.
REQ-015 ALL_RED -> PED_WALK when timer == CLEAR_T-1.
REQ-016 PED_WALK -> PED_CLEAR when timer == PED_T-1.
REQ-017 PED_CLEAR -> CAR_GREEN when timer == CLEAR_T-1.
REQ-018 Outputs SHALL be a Moore decode of the state register, with no combinational path from buton.
REQ-019 Output decode per state: CAR_GREEN car_green=1, ped_red=1; CAR_YELLOW car_yellow=1, ped_red=1; ALL_RED and PED_CLEAR car_red=1, ped_red=1; PED_WALK car_red=1, ped_green=1.
REQ-020 All output lamps not listed for a state in REQ-019 SHALL be 0.
REQ-021 Exactly one car lamp and exactly one ped lamp SHALL be 1 in every cycle.
REQ-022 car_green and ped_green SHALL never be 1 simultaneously.
REQ-023 The request latch SHALL be set on the edge following buton=1 in states CAR_GREEN, CAR_YELLOW, ALL_RED or PED_CLEAR.
REQ-024 buton in PED_WALK SHALL be ignored, since that request is already being served.
REQ-025 The request latch SHALL clear on the edge that enters PED_WALK.
REQ-026 If buton=1 on the cycle that leaves ALL_RED, clear SHALL win and req_pending SHALL be 0 in the first PED_WALK cycle.
REQ-027 A request latched during PED_CLEAR SHALL persist into CAR_GREEN and be served after MIN_GREEN.
REQ-028 Repeated buton pulses while req_pending=1 SHALL have no additional effect; there is no request counting.
REQ-029 A request arriving after MIN_GREEN has elapsed SHALL move CAR_GREEN -> CAR_YELLOW on the edge after req_pending rises.

Reset
REQ-030 While rst=0: state=CAR_GREEN, timer=0, req_pending=0, car_green=1, ped_red=1, all other lamps 0, asynchronously.
REQ-031 Reset asserted in any state, including mid-PED_WALK, SHALL abort the sequence immediately with no yellow or clear phase; a pending request is discarded.
REQ-032 Cycle 0 is defined as the first rising edge with rst=1; the timer reads 0 in cycle 0.

Verification
REQ-033 Idle: default parameters, no buton for 200 cycles -> car_green=1, ped_red=1, req_pending=0 throughout, state never leaves CAR_GREEN.
REQ-034 Early request: buton pulse in cycle 5 -> req_pending=1 from cycle 6; car_yellow cycles 20-24; all red 25-27; ped_green 28-42 with req_pending=0 from 28; all red 43-45; car_green from 46.
REQ-035 Late request: buton pulse in cycle 50 -> req_pending=1 at 51, car_yellow at 52-56, ped_green at 60-74.
REQ-036 Boundary: buton pulse on the last ALL_RED cycle (27 in REQ-034) -> req_pending=0 at 28; no second walk phase follows. A buton in PED_CLEAR (cycle 44) -> req_pending=1 from 45; second walk starts after a 20-cycle green.
REQ-037 Reset mid-walk: assert rst in cycle 35 of REQ-034 -> car_green=1, ped_red=1, req_pending=0 immediately; after release, behaves as REQ-033.
REQ-038 Minimum parameters: all parameters = 1 with buton held high every cycle -> state sequence repeats with period 5 cycles (green, yellow, all red, walk, all red); lamp invariants of REQ-021 and REQ-022 hold every cycle.
